rob_nway: RTL and testbench
===========================

# rob_nway

Parametrised N-wide reorder buffer for the out-of-order core. It allocates entries in program order for up to NUM_SUPER dispatched instructions per cycle, marks entries complete from the CDB, and retires up to NUM_SUPER in-order, completed instructions per cycle to the Arch Map, Free List, SQ and LQ. Compared with the fixed 2-wide ROB, it adds partial dispatch and retire widths, an explicit occupancy counter, and a single-cycle branch rollback with no post-rollback dispatch stall.

## Interface
- NUM_ROB, 32, entry count; power of two, ≥ 2·NUM_SUPER
- NUM_SUPER, 2, dispatch/complete/retire lanes
- PREG_W, 6, physical register index width
- AREG_W, 5, architectural register index width
- PC_W, 64, NPC width
- IDX_W = $clog2(NUM_ROB) (derived); CNT_W = IDX_W+1 (derived)

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- en  in  1  global enable; state holds when low
- dispatch_valid  in  NUM_SUPER  per-lane dispatch request; must be a lane-0 prefix
- dispatch_ready  out  1  free ≥ NUM_SUPER, no halt/illegal pending, rollback_en low
- disp_T_idx, disp_Told_idx  in  NUM_SUPER×PREG_W  new/old physical destination
- disp_dest_idx  in  NUM_SUPER×AREG_W  architectural destination
- disp_halt, disp_illegal, disp_wr_mem, disp_rd_mem  in  NUM_SUPER  per-lane flags
- disp_NPC  in  NUM_SUPER×PC_W  next PC
- rob_idx  out  NUM_SUPER×IDX_W  lane i = tail+i mod NUM_ROB
- complete_en  in  NUM_SUPER  CDB completion strobes
- complete_idx  in  NUM_SUPER×IDX_W  completing entries
- retire_allow  in  NUM_SUPER  SQ/LQ permission per retire lane
- rollback_en  in  1  mispredict recovery
- rollback_idx  in  IDX_W  mispredicted branch entry (kept)
- retire_en  out  NUM_SUPER  lane-0 prefix of retiring entries
- ret_T_idx, ret_Told_idx, ret_dest_idx, ret_NPC  out  per lane  fields of entry head+i
- ret_wr_mem, ret_rd_mem, halt_out, illegal_out  out  NUM_SUPER  flags, gated by retire_en
- count  out  CNT_W  occupied entries
- full, empty  out  1  count==NUM_ROB / count==0

## Operation
- Entry fields: valid, complete, halt, illegal, wr_mem, rd_mem, T_idx, Told_idx, dest_idx, NPC.
- Dispatch:
  - n_d = popcount(dispatch_valid) when dispatch_ready, else 0.
  - Lane i writes entry tail+i and sets valid.
  - complete is set at dispatch when halt or illegal, otherwise cleared.
  - tail += n_d (mod NUM_ROB).
- Complete: for each complete_en[i] with entry valid, set complete. Strobes to invalid (squashed) entries are ignored. Duplicate indices are harmless.
- Retire: lane i fires iff all of the following hold:
  - i < count
  - entry head+i is valid and complete
  - retire_allow[i]
  - retire_en[i-1], and lane i-1 is not halt/illegal
  - rollback_en is low
- On retire, n_r = popcount(retire_en); those entries are cleared and head += n_r.
- Halt pending:
  - Sticky flag, set on dispatch of a halt/illegal instruction.
  - Cleared on reset only, or by a rollback that squashes the entry. It is tracked as a count of valid halt/illegal entries.
  - While the flag is set, dispatch_ready is low.
- Rollback (rollback_en is ignored if entry rollback_idx is invalid):
  - Invalidate every entry strictly younger than rollback_idx, up to tail-1, handling wrap-around.
  - tail = rollback_idx+1.
  - count = ((rollback_idx - head) mod NUM_ROB) + 1.
  - Rollback wins over same-cycle dispatch and retire. Completions to surviving entries still apply.
- count_next = count + n_d - n_r. Overflow and underflow are impossible by construction; the assertion must fire if either occurs.

## Timing
- Reset values:
  - head=tail=count=0, all valid/complete=0, halt pending=0.
  - empty=1, full=0, dispatch_ready=1, retire_en=0, rob_idx[i]=i.
- Combinational paths:
  - dispatch_ready, rob_idx, retire_en, ret_* and halt/illegal_out are combinational from registered state plus retire_allow/rollback_en.
  - dispatch_ready uses the registered count only, so same-cycle retires do not free slots for dispatch.
- Latencies:
  - Dispatch → earliest retire: 2 cycles.
  - Completion strobe → retire: next cycle.
  - Rollback → dispatch may resume: next cycle.
- en low freezes all state. Outputs still reflect the held state.
- reset mid-operation flushes everything on that edge.

## Test plan
- Reset, then dispatch 2/cycle for 16 cycles with NUM_ROB=32 → full=1, count=32, dispatch_ready=0, rob_idx wraps 30,31 → 0,1.
- Dispatch entries 0..3, complete 1 and 0 → cycle after the last completion retire_en=2'b11 for entries 0,1; entries 2,3 are held until complete.
- head=28, tail=4 (wrapped), rollback_idx=30 → entries 31,0..3 invalid, tail=31, count=3; complete_idx=1 later is ignored.
- Halt dispatched in lane 0 with a normal op in lane 1 → dispatch_ready=0 from the next cycle; the halt retires with halt_out[0]=1 and retire_en[1]=0.
- retire_allow=2'b01 with two completed head entries → retire_en=2'b01, head+=1; same cycle dispatch of 2 → count +1.
- Rollback and a 2-lane dispatch in the same cycle → dispatch ignored; tail=rollback_idx+1; no retire that cycle.

Source files
------------

// File: rtl/rob_nway_if.sv
// rob_nway_if: dispatch / completion / retire / rollback bundle of the
// N-wide reorder buffer.
//   master : the core side. It drives dispatch, CDB completions, SQ/LQ
//            retire permission and branch rollback.
//   slave  : the ROB. It returns dispatch_ready, allocated rob_idx, the
//            retiring entry fields and the occupancy status.
// Multi-lane signals are packed [lane][field] arrays; lane 0 is oldest.
interface rob_nway_if #(
    parameter int NUM_ROB   = 32,
    parameter int NUM_SUPER = 2,
    parameter int PREG_W    = 6,
    parameter int AREG_W    = 5,
    parameter int PC_W      = 64
);
    localparam int IDX_W = $clog2(NUM_ROB);
    localparam int CNT_W = IDX_W + 1;

    // Dispatch
    logic [NUM_SUPER-1:0]             dispatch_valid;
    logic                             dispatch_ready;
    logic [NUM_SUPER-1:0][PREG_W-1:0] disp_T_idx;
    logic [NUM_SUPER-1:0][PREG_W-1:0] disp_Told_idx;
    logic [NUM_SUPER-1:0][AREG_W-1:0] disp_dest_idx;
    logic [NUM_SUPER-1:0]             disp_halt;
    logic [NUM_SUPER-1:0]             disp_illegal;
    logic [NUM_SUPER-1:0]             disp_wr_mem;
    logic [NUM_SUPER-1:0]             disp_rd_mem;
    logic [NUM_SUPER-1:0][PC_W-1:0]   disp_NPC;
    logic [NUM_SUPER-1:0][IDX_W-1:0]  rob_idx;

    // Completion (CDB)
    logic [NUM_SUPER-1:0]             complete_en;
    logic [NUM_SUPER-1:0][IDX_W-1:0]  complete_idx;

    // Rollback
    logic                             rollback_en;
    logic [IDX_W-1:0]                 rollback_idx;

    // Retire
    logic [NUM_SUPER-1:0]             retire_allow;
    logic [NUM_SUPER-1:0]             retire_en;
    logic [NUM_SUPER-1:0][PREG_W-1:0] ret_T_idx;
    logic [NUM_SUPER-1:0][PREG_W-1:0] ret_Told_idx;
    logic [NUM_SUPER-1:0][AREG_W-1:0] ret_dest_idx;
    logic [NUM_SUPER-1:0][PC_W-1:0]   ret_NPC;
    logic [NUM_SUPER-1:0]             ret_wr_mem;
    logic [NUM_SUPER-1:0]             ret_rd_mem;
    logic [NUM_SUPER-1:0]             halt_out;
    logic [NUM_SUPER-1:0]             illegal_out;

    // Occupancy
    logic [CNT_W-1:0]                 count;
    logic                             full;
    logic                             empty;

    modport master (
        output dispatch_valid, disp_T_idx, disp_Told_idx, disp_dest_idx,
               disp_halt, disp_illegal, disp_wr_mem, disp_rd_mem, disp_NPC,
               complete_en, complete_idx, rollback_en, rollback_idx,
               retire_allow,
        input  dispatch_ready, rob_idx, retire_en, ret_T_idx, ret_Told_idx,
               ret_dest_idx, ret_NPC, ret_wr_mem, ret_rd_mem, halt_out,
               illegal_out, count, full, empty
    );

    modport slave (
        input  dispatch_valid, disp_T_idx, disp_Told_idx, disp_dest_idx,
               disp_halt, disp_illegal, disp_wr_mem, disp_rd_mem, disp_NPC,
               complete_en, complete_idx, rollback_en, rollback_idx,
               retire_allow,
        output dispatch_ready, rob_idx, retire_en, ret_T_idx, ret_Told_idx,
               ret_dest_idx, ret_NPC, ret_wr_mem, ret_rd_mem, halt_out,
               illegal_out, count, full, empty
    );
endinterface

// File: rtl/rob_nway.sv
// rob_nway: parametrised N-wide reorder buffer.
// Allocates up to NUM_SUPER entries per cycle in program order at the tail,
// marks entries complete from the CDB, retires up to NUM_SUPER in-order
// completed entries per cycle from the head, and recovers from a branch
// mispredict in one cycle by squashing everything younger than the branch.
// Ports:
//   clock  : clock
//   reset  : synchronous, active-high; flushes the whole buffer
//   en     : global enable; all state holds while low
//   bus    : rob_nway_if.slave (dispatch, completion, retire, rollback,
//            occupancy)
// Retire outputs are not qualified by en: while the core is globally
// stalled, consumers of retire_en are stalled by the same en.
module rob_nway #(
    parameter int NUM_ROB   = 32,
    parameter int NUM_SUPER = 2,
    parameter int PREG_W    = 6,
    parameter int AREG_W    = 5,
    parameter int PC_W      = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    rob_nway_if.slave     bus
);
    localparam int IDX_W = $clog2(NUM_ROB);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic              valid;
        logic              complete;
        logic              halt;
        logic              illegal;
        logic              wr_mem;
        logic              rd_mem;
        logic [PREG_W-1:0] t_idx;
        logic [PREG_W-1:0] told_idx;
        logic [AREG_W-1:0] dest_idx;
        logic [PC_W-1:0]   npc;
    } entry_t;

    entry_t               entry_q [NUM_ROB];
    entry_t               entry_d [NUM_ROB];
    logic [IDX_W-1:0]     head_q, head_d;
    logic [IDX_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    // Number of dispatched halt/illegal entries not squashed by rollback;
    // nonzero means "halt pending" and blocks further dispatch.
    logic [CNT_W-1:0]     halt_cnt_q, halt_cnt_d;

    logic                 disp_ok;
    logic [NUM_SUPER-1:0] fire;
    logic [CNT_W-1:0]     num_disp;
    logic [CNT_W-1:0]     num_ret;

    // ------------------------------------------------------------------
    // Dispatch readiness and retire selection (combinational outputs)
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default at the top of the block
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic [IDX_W-1:0] slot;
        logic             chain;
        slot  = '0;
        chain = 1'b1;
        fire  = '0;

        // Only the registered count is used, so same-cycle retires never
        // free slots for dispatch.
        disp_ok = ((CNT_W'(NUM_ROB) - count_q) >= CNT_W'(NUM_SUPER)) &&
                  (halt_cnt_q == '0) && !bus.rollback_en;

        for (int i = 0; i < NUM_SUPER; i++) begin
            slot = head_q + IDX_W'(i);
            fire[i] = chain && (CNT_W'(i) < count_q) &&
                      entry_q[slot].valid && entry_q[slot].complete &&
                      bus.retire_allow[i] && !bus.rollback_en;
            // A halt/illegal entry is the last one retired in its cycle.
            chain = fire[i] && !(entry_q[slot].halt || entry_q[slot].illegal);

            bus.rob_idx[i]      = tail_q + IDX_W'(i);
            bus.ret_T_idx[i]    = entry_q[slot].t_idx;
            bus.ret_Told_idx[i] = entry_q[slot].told_idx;
            bus.ret_dest_idx[i] = entry_q[slot].dest_idx;
            bus.ret_NPC[i]      = entry_q[slot].npc;
            bus.ret_wr_mem[i]   = fire[i] && entry_q[slot].wr_mem;
            bus.ret_rd_mem[i]   = fire[i] && entry_q[slot].rd_mem;
            bus.halt_out[i]     = fire[i] && entry_q[slot].halt;
            bus.illegal_out[i]  = fire[i] && entry_q[slot].illegal;
        end

        bus.dispatch_ready = disp_ok;
        bus.retire_en      = fire;
        bus.count          = count_q;
        bus.full           = (count_q == CNT_W'(NUM_ROB));
        bus.empty          = (count_q == '0);
    end

    // ------------------------------------------------------------------
    // Next-state: dispatch, completion, retire, rollback (in that priority
    // order, later updates override earlier ones on the same entry)
    // ------------------------------------------------------------------
    always_comb begin
        logic [IDX_W-1:0] slot;
        logic [IDX_W-1:0] age;
        logic [IDX_W-1:0] rb_age;
        logic             rb_fire;
        logic [CNT_W-1:0] halt_add;
        logic [CNT_W-1:0] halt_sq;
        slot     = '0;
        age      = '0;
        halt_add = '0;
        halt_sq  = '0;
        num_disp = '0;
        num_ret  = '0;
        entry_d  = entry_q;

        // Dispatch: dispatch_valid is a lane-0 prefix, so lane i maps to tail+i.
        for (int i = 0; i < NUM_SUPER; i++) begin
            if (disp_ok && bus.dispatch_valid[i]) begin
                slot = tail_q + IDX_W'(i);
                entry_d[slot].valid    = 1'b1;
                entry_d[slot].complete = bus.disp_halt[i] || bus.disp_illegal[i];
                entry_d[slot].halt     = bus.disp_halt[i];
                entry_d[slot].illegal  = bus.disp_illegal[i];
                entry_d[slot].wr_mem   = bus.disp_wr_mem[i];
                entry_d[slot].rd_mem   = bus.disp_rd_mem[i];
                entry_d[slot].t_idx    = bus.disp_T_idx[i];
                entry_d[slot].told_idx = bus.disp_Told_idx[i];
                entry_d[slot].dest_idx = bus.disp_dest_idx[i];
                entry_d[slot].npc      = bus.disp_NPC[i];
                num_disp = num_disp + CNT_W'(1);
                if (bus.disp_halt[i] || bus.disp_illegal[i])
                    halt_add = halt_add + CNT_W'(1);
            end
        end

        // Completion: strobes to squashed (invalid) entries are dropped.
        for (int i = 0; i < NUM_SUPER; i++) begin
            if (bus.complete_en[i] && entry_q[bus.complete_idx[i]].valid)
                entry_d[bus.complete_idx[i]].complete = 1'b1;
        end

        // Retire.
        for (int i = 0; i < NUM_SUPER; i++) begin
            if (fire[i]) begin
                slot = head_q + IDX_W'(i);
                entry_d[slot].valid    = 1'b0;
                entry_d[slot].complete = 1'b0;
                num_ret = num_ret + CNT_W'(1);
            end
        end

        // Rollback: age is measured from head, so "younger than the branch"
        // is a plain compare that handles wrap-around.
        rb_fire = bus.rollback_en && entry_q[bus.rollback_idx].valid;
        rb_age  = bus.rollback_idx - head_q;
        if (rb_fire) begin
            for (int j = 0; j < NUM_ROB; j++) begin
                age = IDX_W'(j) - head_q;
                if (entry_q[j].valid && (age > rb_age)) begin
                    entry_d[j].valid    = 1'b0;
                    entry_d[j].complete = 1'b0;
                    if (entry_q[j].halt || entry_q[j].illegal)
                        halt_sq = halt_sq + CNT_W'(1);
                end
            end
        end

        // rollback_en blocks dispatch and retire, so num_disp/num_ret are
        // zero whenever rb_fire is set.
        head_d     = head_q + num_ret[IDX_W-1:0];
        halt_cnt_d = halt_cnt_q + halt_add - halt_sq;
        if (rb_fire) begin
            tail_d  = bus.rollback_idx + IDX_W'(1);
            count_d = {1'b0, rb_age} + CNT_W'(1);
        end else begin
            tail_d  = tail_q + num_disp[IDX_W-1:0];
            count_d = count_q + num_disp - num_ret;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            halt_cnt_q <= '0;
            // NOTE: only valid/complete are reset; the payload is never read
            // while its entry is invalid, so clearing it buys nothing.
            for (int j = 0; j < NUM_ROB; j++) begin
                entry_q[j].valid    <= 1'b0;
                entry_q[j].complete <= 1'b0;
            end
        end else if (en) begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            halt_cnt_q <= halt_cnt_d;
            entry_q    <= entry_d;
        end
    end

    // Occupancy can neither underflow nor exceed NUM_ROB.
    logic [CNT_W:0] occ_sum;
    assign occ_sum = {1'b0, count_q} + {1'b0, num_disp};

    a_count_bounds: assert property (@(posedge clock) disable iff (reset)
        en |-> ((occ_sum >= {1'b0, num_ret}) &&
                ((occ_sum - {1'b0, num_ret}) <= (CNT_W+1)'(NUM_ROB))));

endmodule

// File: tb/tb_rob_nway.sv
// tb_rob_nway: directed self-checking bench for rob_nway (NUM_ROB=32,
// NUM_SUPER=2). Inputs change on the falling edge; combinational outputs
// are sampled 1 time unit later and registered state after each rising edge.
module tb_rob_nway;
    localparam int NUM_ROB   = 32;
    localparam int NUM_SUPER = 2;
    localparam int PREG_W    = 6;
    localparam int AREG_W    = 5;
    localparam int PC_W      = 64;
    localparam int IDX_W     = 5;
    localparam int CNT_W     = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic en    = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    rob_nway_if #(.NUM_ROB(NUM_ROB), .NUM_SUPER(NUM_SUPER), .PREG_W(PREG_W),
                  .AREG_W(AREG_W), .PC_W(PC_W)) bus ();

    rob_nway #(.NUM_ROB(NUM_ROB), .NUM_SUPER(NUM_SUPER), .PREG_W(PREG_W),
               .AREG_W(AREG_W), .PC_W(PC_W)) dut (
        .clock(clock),
        .reset(reset),
        .en   (en),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        bus.dispatch_valid = '0;
        bus.disp_T_idx     = '0;
        bus.disp_Told_idx  = '0;
        bus.disp_dest_idx  = '0;
        bus.disp_halt      = '0;
        bus.disp_illegal   = '0;
        bus.disp_wr_mem    = '0;
        bus.disp_rd_mem    = '0;
        bus.disp_NPC       = '0;
        bus.complete_en    = '0;
        bus.complete_idx   = '0;
        bus.retire_allow   = '1;
        bus.rollback_en    = 1'b0;
        bus.rollback_idx   = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        en    = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    // Lane i carries tag base+i in T_idx/dest and NPC = 4*(base+i).
    task automatic set_dispatch(input logic [1:0] v, input int base);
        bus.dispatch_valid = v;
        for (int i = 0; i < NUM_SUPER; i++) begin
            bus.disp_T_idx[i]    = PREG_W'(base + i);
            bus.disp_Told_idx[i] = PREG_W'(base + i + 32);
            bus.disp_dest_idx[i] = AREG_W'(base + i);
            bus.disp_NPC[i]      = PC_W'(4 * (base + i));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        #1;
        tests_run++; if (bus.empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %0b want 1", bus.empty); end
        tests_run++; if (bus.full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %0b want 0", bus.full); end
        tests_run++; if (bus.count !== 6'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        tests_run++; if (bus.dispatch_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %0b want 1", bus.dispatch_ready); end
        tests_run++; if (bus.retire_en !== 2'b00) begin tests_failed++; $display("FAIL reset_retire_en: got %b want 00", bus.retire_en); end
        tests_run++; if (bus.rob_idx !== {5'd1, 5'd0}) begin tests_failed++; $display("FAIL reset_rob_idx: got %h want %h", bus.rob_idx, {5'd1, 5'd0}); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            set_dispatch(2'b11, 2 * k);
            #1;
            tests_run++;
            if (bus.rob_idx !== {IDX_W'(2 * k + 1), IDX_W'(2 * k)}) begin
                tests_failed++;
                $display("FAIL fill_rob_idx[%0d]: got %h want %h", k, bus.rob_idx, {IDX_W'(2 * k + 1), IDX_W'(2 * k)});
            end
            tick();
        end
        clear_inputs();
        #1;
        tests_run++; if (bus.count !== 6'd32) begin tests_failed++; $display("FAIL fill_count: got %0d want 32", bus.count); end
        tests_run++; if (bus.full !== 1'b1) begin tests_failed++; $display("FAIL fill_full: got %0b want 1", bus.full); end
        tests_run++; if (bus.empty !== 1'b0) begin tests_failed++; $display("FAIL fill_empty: got %0b want 0", bus.empty); end
        tests_run++; if (bus.dispatch_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_ready: got %0b want 0", bus.dispatch_ready); end
        tests_run++; if (bus.rob_idx !== {5'd1, 5'd0}) begin tests_failed++; $display("FAIL fill_rob_idx_wrap: got %h want %h", bus.rob_idx, {5'd1, 5'd0}); end
    endtask

    task automatic test_complete_retire();
        do_reset();
        set_dispatch(2'b11, 0); tick();
        set_dispatch(2'b11, 2); tick();
        clear_inputs();
        bus.complete_en = 2'b01; bus.complete_idx[0] = 5'd1;
        #1;
        tests_run++; if (bus.retire_en !== 2'b00) begin tests_failed++; $display("FAIL cr_no_retire_a: got %b want 00", bus.retire_en); end
        tick();
        bus.complete_idx[0] = 5'd0;
        #1;
        tests_run++; if (bus.retire_en !== 2'b00) begin tests_failed++; $display("FAIL cr_head_incomplete: got %b want 00", bus.retire_en); end
        tick();
        clear_inputs();
        #1;
        tests_run++; if (bus.retire_en !== 2'b11) begin tests_failed++; $display("FAIL cr_retire_pair: got %b want 11", bus.retire_en); end
        tests_run++; if (bus.ret_T_idx !== {6'd1, 6'd0}) begin tests_failed++; $display("FAIL cr_ret_T_idx: got %h want %h", bus.ret_T_idx, {6'd1, 6'd0}); end
        tests_run++; if (bus.ret_NPC[1] !== 64'd4) begin tests_failed++; $display("FAIL cr_ret_NPC1: got %0d want 4", bus.ret_NPC[1]); end
        tick();
        #1;
        tests_run++; if (bus.count !== 6'd2) begin tests_failed++; $display("FAIL cr_count_after: got %0d want 2", bus.count); end
        tests_run++; if (bus.retire_en !== 2'b00) begin tests_failed++; $display("FAIL cr_hold_incomplete: got %b want 00", bus.retire_en); end
        bus.complete_en = 2'b11; bus.complete_idx = {5'd3, 5'd2};
        tick();
        clear_inputs();
        #1;
        tests_run++; if (bus.retire_en !== 2'b11) begin tests_failed++; $display("FAIL cr_retire_second: got %b want 11", bus.retire_en); end
        tick();
        #1;
        tests_run++; if (bus.empty !== 1'b1) begin tests_failed++; $display("FAIL cr_empty: got %0b want 1", bus.empty); end
    endtask

    task automatic test_rollback_wrap();
        do_reset();
        for (int k = 0; k < 14; k++) begin
            set_dispatch(2'b11, 2 * k); tick();
        end
        clear_inputs();
        // Complete pairs back to back; each pair retires the following cycle.
        for (int k = 0; k < 14; k++) begin
            bus.complete_en  = 2'b11;
            bus.complete_idx = {IDX_W'(2 * k + 1), IDX_W'(2 * k)};
            tick();
        end
        clear_inputs();
        tick();
        #1;
        tests_run++; if (bus.count !== 6'd0) begin tests_failed++; $display("FAIL rbw_drain_count: got %0d want 0", bus.count); end
        set_dispatch(2'b11, 28); tick();
        set_dispatch(2'b11, 30); tick();
        set_dispatch(2'b11, 0);  tick();
        set_dispatch(2'b11, 2);  tick();
        clear_inputs();
        #1;
        tests_run++; if ({bus.count, bus.rob_idx[0]} !== {6'd8, 5'd4}) begin tests_failed++; $display("FAIL rbw_setup: got count %0d tail %0d want 8 4", bus.count, bus.rob_idx[0]); end
        bus.rollback_en = 1'b1; bus.rollback_idx = 5'd30;
        #1;
        tests_run++; if (bus.dispatch_ready !== 1'b0) begin tests_failed++; $display("FAIL rbw_ready_during: got %0b want 0", bus.dispatch_ready); end
        tick();
        clear_inputs();
        #1;
        tests_run++; if (bus.count !== 6'd3) begin tests_failed++; $display("FAIL rbw_count: got %0d want 3", bus.count); end
        tests_run++; if (bus.rob_idx !== {5'd0, 5'd31}) begin tests_failed++; $display("FAIL rbw_tail: got %h want %h", bus.rob_idx, {5'd0, 5'd31}); end
        tests_run++; if (bus.dispatch_ready !== 1'b1) begin tests_failed++; $display("FAIL rbw_ready_after: got %0b want 1", bus.dispatch_ready); end
        bus.complete_en = 2'b01; bus.complete_idx[0] = 5'd1;
        tick();
        clear_inputs();
        #1;
        tests_run++; if ({bus.count, bus.retire_en} !== {6'd3, 2'b00}) begin tests_failed++; $display("FAIL rbw_squashed_complete: got count %0d retire %b want 3 00", bus.count, bus.retire_en); end
        bus.complete_en = 2'b11; bus.complete_idx = {5'd29, 5'd28};
        tick();
        clear_inputs();
        #1;
        tests_run++; if (bus.retire_en !== 2'b11) begin tests_failed++; $display("FAIL rbw_retire_28_29: got %b want 11", bus.retire_en); end
        tick();
        #1;
        tests_run++; if (bus.count !== 6'd1) begin tests_failed++; $display("FAIL rbw_count_1: got %0d want 1", bus.count); end
        bus.complete_en = 2'b01; bus.complete_idx[0] = 5'd30;
        tick();
        clear_inputs();
        #1;
        tests_run++; if (bus.retire_en !== 2'b01) begin tests_failed++; $display("FAIL rbw_retire_30: got %b want 01", bus.retire_en); end
        tick();
        #1;
        tests_run++; if (bus.empty !== 1'b1) begin tests_failed++; $display("FAIL rbw_empty: got %0b want 1", bus.empty); end
    endtask

    task automatic test_halt();
        do_reset();
        set_dispatch(2'b11, 0);
        bus.disp_halt = 2'b01;
        #1;
        tests_run++; if (bus.dispatch_ready !== 1'b1) begin tests_failed++; $display("FAIL halt_ready_before: got %0b want 1", bus.dispatch_ready); end
        tick();
        clear_inputs();
        bus.retire_allow = 2'b00;
        bus.complete_en = 2'b01; bus.complete_idx[0] = 5'd1;
        #1;
        tests_run++; if (bus.dispatch_ready !== 1'b0) begin tests_failed++; $display("FAIL halt_ready_after: got %0b want 0", bus.dispatch_ready); end
        tests_run++; if (bus.retire_en !== 2'b00) begin tests_failed++; $display("FAIL halt_no_allow: got %b want 00", bus.retire_en); end
        tick();
        clear_inputs();
        #1;
        tests_run++; if (bus.retire_en !== 2'b01) begin tests_failed++; $display("FAIL halt_retire_en: got %b want 01", bus.retire_en); end
        tests_run++; if (bus.halt_out !== 2'b01) begin tests_failed++; $display("FAIL halt_out: got %b want 01", bus.halt_out); end
        tick();
        #1;
        tests_run++; if ({bus.count, bus.retire_en, bus.halt_out} !== {6'd1, 2'b01, 2'b00}) begin tests_failed++; $display("FAIL halt_next_op: got count %0d retire %b halt %b want 1 01 00", bus.count, bus.retire_en, bus.halt_out); end
        tick();
        #1;
        tests_run++; if ({bus.count, bus.dispatch_ready} !== {6'd0, 1'b0}) begin tests_failed++; $display("FAIL halt_sticky: got count %0d ready %0b want 0 0", bus.count, bus.dispatch_ready); end
    endtask

    task automatic test_partial_retire();
        do_reset();
        set_dispatch(2'b11, 0); tick();
        clear_inputs();
        bus.complete_en = 2'b11; bus.complete_idx = {5'd1, 5'd0};
        tick();
        clear_inputs();
        set_dispatch(2'b11, 2);
        bus.retire_allow = 2'b01;
        #1;
        tests_run++; if (bus.retire_en !== 2'b01) begin tests_failed++; $display("FAIL pr_retire_en: got %b want 01", bus.retire_en); end
        tests_run++; if (bus.dispatch_ready !== 1'b1) begin tests_failed++; $display("FAIL pr_ready: got %0b want 1", bus.dispatch_ready); end
        tick();
        clear_inputs();
        #1;
        tests_run++; if (bus.count !== 6'd3) begin tests_failed++; $display("FAIL pr_count: got %0d want 3", bus.count); end
        tests_run++; if ({bus.ret_T_idx[0], bus.retire_en} !== {6'd1, 2'b01}) begin tests_failed++; $display("FAIL pr_head_moved: got T %0d retire %b want 1 01", bus.ret_T_idx[0], bus.retire_en); end
    endtask

    task automatic test_rollback_vs_dispatch();
        do_reset();
        set_dispatch(2'b11, 0); tick();
        set_dispatch(2'b11, 2); tick();
        clear_inputs();
        bus.complete_en = 2'b01; bus.complete_idx[0] = 5'd0;
        tick();
        clear_inputs();
        bus.rollback_en = 1'b1; bus.rollback_idx = 5'd1;
        set_dispatch(2'b11, 4);
        #1;
        tests_run++; if ({bus.dispatch_ready, bus.retire_en} !== {1'b0, 2'b00}) begin tests_failed++; $display("FAIL rvd_blocked: got ready %0b retire %b want 0 00", bus.dispatch_ready, bus.retire_en); end
        tick();
        clear_inputs();
        #1;
        tests_run++; if (bus.count !== 6'd2) begin tests_failed++; $display("FAIL rvd_count: got %0d want 2", bus.count); end
        tests_run++; if (bus.rob_idx !== {5'd3, 5'd2}) begin tests_failed++; $display("FAIL rvd_tail: got %h want %h", bus.rob_idx, {5'd3, 5'd2}); end
        tests_run++; if ({bus.retire_en, bus.dispatch_ready} !== {2'b01, 1'b1}) begin tests_failed++; $display("FAIL rvd_resume: got retire %b ready %0b want 01 1", bus.retire_en, bus.dispatch_ready); end
        // Rollback to an invalid entry changes nothing but still blocks retire.
        bus.rollback_en = 1'b1; bus.rollback_idx = 5'd9;
        #1;
        tests_run++; if (bus.retire_en !== 2'b00) begin tests_failed++; $display("FAIL rvd_invalid_rb_retire: got %b want 00", bus.retire_en); end
        tick();
        clear_inputs();
        #1;
        tests_run++; if ({bus.count, bus.rob_idx[0]} !== {6'd2, 5'd2}) begin tests_failed++; $display("FAIL rvd_invalid_rb_state: got count %0d tail %0d want 2 2", bus.count, bus.rob_idx[0]); end
    endtask

    task automatic test_enable_and_reset();
        do_reset();
        en = 1'b0;
        set_dispatch(2'b11, 0);
        tick();
        #1;
        tests_run++; if ({bus.count, bus.rob_idx[0]} !== {6'd0, 5'd0}) begin tests_failed++; $display("FAIL en_freeze: got count %0d tail %0d want 0 0", bus.count, bus.rob_idx[0]); end
        en = 1'b1;
        tick();
        #1;
        tests_run++; if (bus.count !== 6'd2) begin tests_failed++; $display("FAIL en_resume: got %0d want 2", bus.count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_inputs();
        #1;
        tests_run++; if ({bus.count, bus.empty, bus.rob_idx[0]} !== {6'd0, 1'b1, 5'd0}) begin tests_failed++; $display("FAIL mid_reset: got count %0d empty %0b tail %0d want 0 1 0", bus.count, bus.empty, bus.rob_idx[0]); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fill_wrap();
        test_complete_retire();
        test_rollback_wrap();
        test_halt();
        test_partial_retire();
        test_rollback_vs_dispatch();
        test_enable_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
